reg_pipeline: RTL and testbench

//  Parametrised multi-stage register pipeline with valid/ready flow control, bubble collapse and flush.

---
 rtl/reg_pipe_pkg.sv | 24 ++
 rtl/reg_pipe_stage.sv | 46 ++++
 rtl/reg_pipeline.sv | 116 +++++++++++
 tb/tb_reg_pipeline.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pipe_pkg.sv
// Shared definitions for the reg_pipeline slice: width helper, default reset value, stage record.
package reg_pipe_pkg;

  localparam int DEF_WIDTH = 8;
  localparam logic [DEF_WIDTH-1:0] DEF_RST_VAL = '0;

  // Contents of one stage at the default data width.
  typedef struct packed {
    logic                 valid;
    logic                 parity;
    logic [DEF_WIDTH-1:0] data;
  } stage_rec_t;

  // Ceiling log2; occupancy is sized with clog2(DEPTH+1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: valid/data registers with load, advance, flush and reset.
// The parity bit is present only when REG_PIPELINE_PARITY_EN is defined.
module reg_pipe_stage import reg_pipe_pkg::*; #(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             adv,
  input  logic [WIDTH-1:0] d,
`ifdef REG_PIPELINE_PARITY_EN
  input  logic             d_par,
  output logic             par,
`endif
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Flush clears only the valid bit; data keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= RST_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
      data  <= d;
    end else if (adv) begin
      valid <= 1'b0;
    end
  end

`ifdef REG_PIPELINE_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 1'b0;
    end else if (!flush && push) begin
      par <= d_par;
    end
  end
`endif

endmodule

// File: rtl/reg_pipeline.sv
// WIDTH x DEPTH register pipeline with valid/ready flow control, bubble collapse and flush.
// Optional parity protection (out_par_err) under macro REG_PIPELINE_PARITY_EN.
module reg_pipeline import reg_pipe_pkg::*; #(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
`ifdef REG_PIPELINE_PARITY_EN
  output logic                         out_par_err,
`endif
  output logic [clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int OCC_W = clog2(DEPTH + 1);

  // Handshake: a word moves across an interface on a rising edge exactly when valid and ready
  // are both high; valid never depends on ready, ready is combinational from out_ready back.
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] push;
  logic [WIDTH-1:0] data    [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic             accept;
  logic             out_xfer;

  always_comb begin
    adv = '0;
    adv[DEPTH-1] = valid[DEPTH-1] & out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = valid[k] & (~valid[k+1] | adv[k+1]);
    end
    in_ready = ~flush & (~valid[0] | adv[0]);
    accept   = in_valid & in_ready;
    push     = '0;
    push[0]  = accept;
    for (int k = 1; k < DEPTH; k++) begin
      push[k] = adv[k-1];
    end
  end

  always_comb begin
    stage_d[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = data[k-1];
    end
  end

`ifdef REG_PIPELINE_PARITY_EN
  logic [DEPTH-1:0] par;
  logic [DEPTH-1:0] par_d;

  // Even parity: data plus parity bit always carries an even number of ones.
  always_comb begin
    par_d    = '0;
    par_d[0] = ^in_data;
    for (int k = 1; k < DEPTH; k++) begin
      par_d[k] = par[k-1];
    end
  end
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    reg_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[k]),
      .adv   (adv[k]),
      .d     (stage_d[k]),
`ifdef REG_PIPELINE_PARITY_EN
      .d_par (par_d[k]),
      .par   (par[k]),
`endif
      .valid (valid[k]),
      .data  (data[k])
    );
  end

  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign out_xfer  = valid[DEPTH-1] & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occupancy <= '0;
    end else if (accept && !out_xfer) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (!accept && out_xfer) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

`ifdef REG_PIPELINE_PARITY_EN
  // Sticky until reset; a transfer completing in a flush cycle is still checked.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_par_err <= 1'b0;
    end else if (out_xfer && ((^data[DEPTH-1]) != par[DEPTH-1])) begin
      out_par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_pipeline.sv
// Self-checking bench for reg_pipeline (WIDTH=8, DEPTH=4, RST_VAL=0x5A); scoreboard checks every output word.
module tb_reg_pipeline;

  localparam int               WIDTH   = 8;
  localparam int               DEPTH   = 4;
  localparam int               OCC_W   = 3;
  localparam logic [WIDTH-1:0] RST_VAL = 8'h5A;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;
`ifdef REG_PIPELINE_PARITY_EN
  logic             out_par_err;
`endif

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_data;
  int               n_checks = 0;
  int               n_fail   = 0;

  reg_pipeline #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef REG_PIPELINE_PARITY_EN
    .out_par_err (out_par_err),
`endif
    .occupancy (occupancy)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h33;
    out_ready = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: push on accept, pop and compare on output transfer, discard on flush/reset
  always @(negedge clk) begin
    #2;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: out_data %02h, required no output", out_data);
        end else begin
          exp_data = exp_q.pop_front();
          if (out_data !== exp_data) begin
            n_fail++;
            $display("FAIL sb_data: out_data %02h, required %02h", out_data, exp_data);
          end
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  // Driver tasks
  task automatic send(input logic [WIDTH-1:0] d);
    int cnt;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready 0 after 50 cycles, required 1");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int cnt;
    @(negedge clk);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    while (cnt < budget) begin
      #3;
      if (exp_q.size() == 0) break;
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d words still expected, required 0", exp_q.size());
    end
  endtask

  // Tests
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: %b, required 0", out_valid); end
    n_checks++;
    if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy: %0d, required 0", occupancy); end
    n_checks++;
    if (out_data !== RST_VAL) begin n_fail++; $display("FAIL reset_out_data: %02h, required %02h", out_data, RST_VAL); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: %b, required 1", in_ready); end
`ifdef REG_PIPELINE_PARITY_EN
    n_checks++;
    if (out_par_err !== 1'b0) begin n_fail++; $display("FAIL reset_par_err: %b, required 0", out_par_err); end
`endif
  endtask

  task automatic test_streaming();
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'(j);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready: cycle %0d %b, required 1", j, in_ready); end
      n_checks++;
      if (out_valid !== (j >= 5)) begin n_fail++; $display("FAIL stream_latency: cycle %0d out_valid %b, required %b", j, out_valid, (j >= 5)); end
      if (j >= 5) begin
        n_checks++;
        if (out_data !== 8'(j - 4)) begin n_fail++; $display("FAIL stream_data: cycle %0d %02h, required %02h", j, out_data, 8'(j - 4)); end
      end
    end
    drain(20);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hA1 + 8'(i);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ready: word %0d %b, required 1", i, in_ready); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hA5;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: %b, required 0", in_ready); end
      n_checks++;
      if (occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_occupancy: %0d, required 4", occupancy); end
      n_checks++;
      if (out_data !== 8'hA1) begin n_fail++; $display("FAIL bp_hold: %02h, required a1", out_data); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: %b, required 1", in_ready); end
    send(8'hA6);
    drain(20);
  endtask

  task automatic test_bubble_collapse();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hB1;
    idle(2);
    send(8'hB2);
    idle(3);
    #1;
    n_checks++;
    if (occupancy !== 3'd2) begin n_fail++; $display("FAIL bubble_occupancy: %0d, required 2", occupancy); end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB1) begin n_fail++; $display("FAIL bubble_stage3: valid %b data %02h, required 1 b1", out_valid, out_data); end
    n_checks++;
    if (dut.g_stage[2].u_stage.valid !== 1'b1 || dut.g_stage[2].u_stage.data !== 8'hB2) begin
      n_fail++;
      $display("FAIL bubble_stage2: valid %b data %02h, required 1 b2", dut.g_stage[2].u_stage.valid, dut.g_stage[2].u_stage.data);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bubble_in_ready: %b, required 1", in_ready); end
    drain(20);
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0;
    send(8'hC1);
    send(8'hC2);
    send(8'hC3);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    n_checks++;
    if (occupancy !== 3'd3) begin n_fail++; $display("FAIL flush_pre_occupancy: %0d, required 3", occupancy); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: %b, required 0", in_ready); end
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear: occupancy %0d out_valid %b, required 0 0", occupancy, out_valid); end
    n_checks++;
    if (dut.g_stage[2].u_stage.data !== 8'hC1) begin n_fail++; $display("FAIL flush_data_kept: %02h, required c1", dut.g_stage[2].u_stage.data); end
    out_ready = 1'b1;
    send(8'h77);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_restart_early: cycle %0d out_valid %b, required 0", i, out_valid); end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h77) begin n_fail++; $display("FAIL flush_restart: valid %b data %02h, required 1 77", out_valid, out_data); end
    drain(20);
  endtask

  task automatic test_flush_with_transfer();
    @(negedge clk);
    out_ready = 1'b0;
    send(8'hD1);
    send(8'hD2);
    idle(2);
    @(negedge clk);
    in_valid  = 1'b0;
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hD1) begin n_fail++; $display("FAIL flushx_head: valid %b data %02h, required 1 d1", out_valid, out_data); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flushx_clear: occupancy %0d out_valid %b, required 0 0", occupancy, out_valid); end
    idle(6);
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      #1;
      n_checks++;
      if (occupancy !== OCC_W'(exp_q.size())) begin
        n_fail++;
        $display("FAIL rand_occupancy: cycle %0d %0d, required %0d", i, occupancy, exp_q.size());
      end
    end
    drain(20);
  endtask

`ifdef REG_PIPELINE_PARITY_EN
  task automatic test_parity();
    @(negedge clk);
    out_ready = 1'b0;
    send(8'h03);
    send(8'h07);
    idle(2);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (dut.g_stage[2].u_stage.valid !== 1'b1 || dut.g_stage[2].u_stage.data !== 8'h07) begin
      n_fail++;
      $display("FAIL par_setup: stage2 valid %b data %02h, required 1 07", dut.g_stage[2].u_stage.valid, dut.g_stage[2].u_stage.data);
    end
    force dut.g_stage[2].u_stage.par = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    release dut.g_stage[2].u_stage.par;
    #1;
    n_checks++;
    if (out_par_err !== 1'b0) begin n_fail++; $display("FAIL par_good_word: %b, required 0", out_par_err); end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (out_par_err !== 1'b1) begin n_fail++; $display("FAIL par_bad_word: %b, required 1", out_par_err); end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++;
    if (out_par_err !== 1'b1) begin n_fail++; $display("FAIL par_sticky: %b, required 1", out_par_err); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_par_err !== 1'b0) begin n_fail++; $display("FAIL par_reset: %b, required 0", out_par_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_flush();
    test_flush_with_transfer();
    test_random();
`ifdef REG_PIPELINE_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
